// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access pipeline stage: access sizes, FSM states, lane masks.
package mem_stage_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } state_e;

    // Size 2'b11 is handled as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction with sign/zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] rd_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rd_data_i[7:0];
            2'd1:    byte_sel = rd_data_i[15:8];
            2'd2:    byte_sel = rd_data_i[23:16];
            default: byte_sel = rd_data_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
    end

    always_comb begin
        wstrb_o   = LANE_W;
        wdata_o   = st_data_i;
        ld_data_o = rd_data_i;
        case (size_i)
            SZ_B: begin
                wstrb_o   = LANE_B << addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                // Half lane ignores addr bit 0, so a misaligned half uses its aligned lane.
                wstrb_o   = LANE_H << {addr_lo_i[1], 1'b0};
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage with a split addr/data handshake data-memory bus.
// Optional misalignment exception: define MEM_MISALIGN_CHECK_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned PAYLOAD_W = 70
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_allow,
    input  logic                 in_load,
    input  logic                 in_store,
    input  logic [1:0]           in_size,
    input  logic                 in_signed,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [31:0]          in_wdata,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_allow,
    output logic [31:0]          out_rdata,
    output logic                 out_ale,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 dm_req,
    output logic                 dm_wr,
    output logic [3:0]           dm_wstrb,
    output logic [ADDR_W-1:0]    dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_addr_ok,
    input  logic                 dm_data_ok,
    input  logic [31:0]          dm_rdata
);

    state_e               state_q;
    logic                 load_q;
    logic                 store_q;
    logic                 signed_q;
    logic [1:0]           size_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 ale_q;

    logic                 allow;
    logic                 capture;
    logic                 mem_op;
    logic                 mis_d;
    logic [3:0]           lane_strb;
    logic [31:0]          lane_wdata;
    logic [31:0]          lane_ldata;

    assign allow   = (state_q == IDLE) | ((state_q == DONE) & out_allow);
    assign capture = in_valid & allow;
    assign mem_op  = in_load | in_store;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_d = mem_op & is_misaligned(in_size, in_addr[1:0]);
`else
    assign mis_d = 1'b0;
`endif

    mem_lane_align u_align (
        .size_i    (size_q),
        .signed_i  (signed_q),
        .addr_lo_i (addr_q[1:0]),
        .st_data_i (wdata_q),
        .rd_data_i (dm_rdata),
        .wstrb_o   (lane_strb),
        .wdata_o   (lane_wdata),
        .ld_data_o (lane_ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            payload_q <= '0;
            ale_q     <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (dm_addr_ok) state_q <= WAIT;
                end
                WAIT: begin
                    if (dm_data_ok) begin
                        rdata_q <= load_q ? lane_ldata : '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_allow) state_q <= IDLE;
                end
                default: ;
            endcase
            // Capture overrides the DONE->IDLE step so back-to-back ops have no bubble.
            if (capture) begin
                load_q    <= in_load;
                store_q   <= in_store;
                signed_q  <= in_signed;
                size_q    <= in_size;
                addr_q    <= in_addr;
                wdata_q   <= in_wdata;
                payload_q <= in_payload;
                rdata_q   <= '0;
                ale_q     <= mis_d;
                state_q   <= (mem_op && !mis_d) ? REQ : DONE;
            end
        end
    end

    assign in_allow    = allow & ~reset;
    assign out_valid   = (state_q == DONE) & ~reset;
    assign out_rdata   = reset ? '0 : rdata_q;
    assign out_payload = reset ? '0 : payload_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign out_ale     = ale_q & ~reset;
`else
    assign out_ale     = 1'b0;
`endif

    assign dm_req   = (state_q == REQ) & ~reset;
    assign dm_wr    = store_q & ~reset;
    assign dm_wstrb = (store_q && !reset) ? lane_strb : '0;
    assign dm_wdata = (store_q && !reset) ? lane_wdata : '0;
    assign dm_addr  = reset ? '0 : {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Fifth pipeline stage with a variable-latency data-memory interface. It replaces the fixed one-cycle memory stage. It captures one instruction from EXE and issues at most one request on an SRAM-like bus with split address/data handshakes. Sub-word loads are aligned and sign/zero-extended, and stores get byte strobes and lane-replicated data. The result and a pass-through payload go to WB under valid/allow-in flow control.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- PAYLOAD_W, 70, width of opaque pass-through bits (rf write enable/select, dest reg, alu_result, PC, ...)

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  EXE has an instruction for this stage
- in_allow  out  1  stage accepts an instruction this cycle
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store (in_load and in_store are never both set)
- in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- in_signed  in  1  sign-extend sub-word load
- in_addr  in  ADDR_W  effective address
- in_wdata  in  32  store data, right-aligned
- in_payload  in  PAYLOAD_W  carried unchanged to WB
- out_valid  out  1  result valid to WB
- out_allow  in  1  WB allow-in
- out_rdata  out  32  extended load data, 0 for non-loads
- out_ale  out  1  address-alignment exception flag
- out_payload  out  PAYLOAD_W  captured payload
- dm_req  out  1  request valid
- dm_wr  out  1  1 = write
- dm_wstrb  out  4  byte strobes
- dm_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- dm_wdata  out  32  lane-replicated store data
- dm_addr_ok  in  1  request accepted
- dm_data_ok  in  1  read data / write acknowledgement returned
- dm_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE and clears all registers. Every output is 0 during reset.
- Capture happens on in_valid & in_allow. All inputs are registered.
  - A memory op goes to REQ.
  - A non-memory op goes to DONE.
  - A misaligned op (macro on) goes to DONE.
- REQ: dm_req=1 with stable dm_wr/dm_wstrb/dm_addr/dm_wdata. On dm_addr_ok it moves to WAIT.
- WAIT: on dm_data_ok, dm_rdata is aligned/extended into the result register and the FSM moves to DONE. The FSM also moves to DONE for stores.
- dm_data_ok is never sampled in REQ.
- DONE: out_valid=1. On out_allow the FSM goes to IDLE, or back-to-back capture happens if in_valid (next state is REQ or DONE).
- in_allow = (state==IDLE) | (state==DONE & out_allow).
- Store strobes: byte 0001<<a[1:0], half 0011<<{a[1],0}, word 1111. dm_wdata = byte x4 or half x2 replicated.
- Load extraction: byte lane a[1:0], half lane a[1]. Bit 7/15 is extended when in_signed, otherwise zero-extended.

## Timing
- Non-memory op: out_valid the cycle after capture.
- Memory op, zero-wait bus: capture at T, dm_req at T+1 with addr_ok at T+1, data_ok at T+2, out_valid at T+3.
- Each cycle of addr_ok or data_ok stall adds one cycle.
- Only one outstanding request. dm_req is never asserted in WAIT or DONE.
- WB stall in DONE holds out_* stable indefinitely.
- Reset mid-REQ/WAIT abandons the transaction. The memory side shares reset.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - half with a[0]=1, or word with a[1:0]!=0, issues no request.
  - The op goes to DONE with out_ale=1 and out_rdata=0.
- MEM_MISALIGN_CHECK_EN undefined:
  - out_ale is tied 0.
  - The low address bits select lanes as above, and misaligned half/word use the aligned lane.

## Structure
- Package mem_stage_pkg: size encodings (SZ_B/SZ_H/SZ_W), FSM state enum, lane-mask constants.
- Sub-module mem_lane_align: combinational store strobe/data generation and load extraction/extension, instantiated once.

## Test plan
- Non-memory op, payload 0x2A5, out_allow=1 -> out_valid the next cycle, out_payload=0x2A5, out_rdata=0, no dm_req.
- Signed byte load at addr 0x1003, dm_rdata=0x80FF_1234 -> out_rdata=0xFFFF_FF80. Unsigned -> 0x0000_0080. dm_addr=0x1000.
- Half store 0xBEEF at 0x2002 -> dm_wstrb=1100, dm_wdata=0xBEEF_BEEF, dm_wr=1. out_valid follows data_ok.
- addr_ok held low 3 cycles, then data_ok 2 cycles late -> dm_req stable for 4 cycles, out_valid at T+8, in_allow low throughout.
- WB stall 5 cycles in DONE with in_valid high -> outputs held. On release, the next op is captured the same cycle with no bubble.
- Macro on, word load at 0x3002 -> no dm_req, out_ale=1. Reset asserted in WAIT -> IDLE, out_valid=0 the next cycle.
